// File: rtl/ifq.sv
// Instruction fetch queue: compacts masked fetch groups into a circular buffer
// and presents the oldest four entries to decode. Optional counters: IFQ_PERF_EN.
module ifq #(
  parameter int DEPTHLOG2 = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_pc,
  input  logic [3:0][31:0] fetch_word,
  input  logic [3:0]       fetch_mask,
  output logic [3:0][31:0] inst_word,
  output logic [3:0][31:0] inst_pc,
  output logic [3:0]       inst_word_valid,
  input  logic             stall
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]      perf_empty_cycles,
  output logic [31:0]      perf_full_cycles
`endif
);

  localparam int DEPTH = 1 << DEPTHLOG2;
  localparam int CW    = DEPTHLOG2 + 1;

  logic [DEPTH-1:0][31:0] pc_q;
  logic [DEPTH-1:0][31:0] word_q;
  logic [DEPTHLOG2-1:0]   head_q, head_d;
  logic [DEPTHLOG2-1:0]   tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;

  logic                   accept_s;
  logic [2:0]             lane_ofs_s;
  logic [DEPTHLOG2-1:0]   wr_idx_s [4];
  logic [DEPTHLOG2-1:0]   rd_idx_s [4];
  logic [CW-1:0]          n_in_s;
  logic [CW-1:0]          n_out_s;

  // Ready looks only at registered occupancy so stall never reaches fetch_ready.
  assign fetch_ready = (count_q <= CW'(DEPTH - 4));

  // Compaction: each masked lane lands at tail plus the number of masked lanes below it.
  always_comb begin
    accept_s   = fetch_valid & fetch_ready & ~flush;
    lane_ofs_s = 3'd0;
    for (int l = 0; l < 4; l++) begin
      wr_idx_s[l] = tail_q + DEPTHLOG2'(lane_ofs_s);
      if (fetch_mask[l]) begin
        lane_ofs_s = lane_ofs_s + 3'd1;
      end else begin
        lane_ofs_s = lane_ofs_s;
      end
    end
    if (accept_s) begin
      n_in_s = CW'(lane_ofs_s);
    end else begin
      n_in_s = '0;
    end
  end

  // Dequeue amount and next-state pointer/occupancy arithmetic.
  always_comb begin
    if (!stall && !flush) begin
      n_out_s = (count_q > CW'(4)) ? CW'(4) : count_q;
    end else begin
      n_out_s = '0;
    end
    head_d  = head_q + n_out_s[DEPTHLOG2-1:0];
    tail_d  = tail_q + n_in_s[DEPTHLOG2-1:0];
    count_d = count_q + n_in_s - n_out_s;
  end

  // Decode window: wrap-around reads at head+i; valids form a thermometer of min(count,4).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_idx_s[i]        = head_q + DEPTHLOG2'(i);
      inst_pc[i]         = pc_q[rd_idx_s[i]];
      inst_word[i]       = word_q[rd_idx_s[i]];
      inst_word_valid[i] = (count_q > CW'(i));
    end
  end

  // Pointer and occupancy registers; flush discards everything including same-cycle fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; each entry keeps the PC of its original lane, not its compacted slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      word_q <= '0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (accept_s && fetch_mask[l]) begin
          pc_q[wr_idx_s[l]]   <= fetch_pc + (32'(l) << 2);
          word_q[wr_idx_s[l]] <= fetch_word[l];
        end
      end
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] perf_empty_q;
  logic [31:0] perf_full_q;

  // Saturating occupancy counters; flush deliberately leaves them alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_empty_q <= 32'd0;
      perf_full_q  <= 32'd0;
    end else begin
      if ((count_q == '0) && (perf_empty_q != 32'hFFFF_FFFF)) begin
        perf_empty_q <= perf_empty_q + 32'd1;
      end
      if (!fetch_ready && (perf_full_q != 32'hFFFF_FFFF)) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
    end
  end

  assign perf_empty_cycles = perf_empty_q;
  assign perf_full_cycles  = perf_full_q;
`endif

endmodule

// File: doc/ifq.md
# ifq

Instruction fetch queue between the I-cache fetch stage and the 4-wide decode stage. It accepts fetch groups of up to four instruction words per cycle, compacts them in program order into a circular buffer, and presents the oldest four entries as a decode window with per-lane valids. When decode is not stalled, every valid lane in the window is consumed. The queue is emptied by a pipeline redirect.

## Interface
- DEPTHLOG2, default 3: log2 of the entry count. Must be at least 3, so the queue holds at least 8 entries.
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  redirect; discards all entries and any same-cycle fetch.
- fetch_valid  in  1  fetch group present.
- fetch_ready  out  1  queue can accept a full group: free entries ≥ 4.
- fetch_pc  in  32  PC of lane 0. Lane i has PC fetch_pc + 4·i.
- fetch_word  in  32×4  instruction words, lanes 0..3.
- fetch_mask  in  1×4  per-lane valid; any pattern is allowed.
- inst_word  out  32×4  decode window words, entries head..head+3.
- inst_pc  out  32×4  decode window PCs.
- inst_word_valid  out  1×4  lane i valid iff i < count.
- stall  in  1  decode stall; when high, nothing is dequeued.

## Operation
- State:
  - Storage of 2^DEPTHLOG2 entries, each holding a 32-bit PC and a 32-bit word.
  - head and tail pointers, DEPTHLOG2 bits each; they wrap modulo depth.
  - count, DEPTHLOG2+1 bits, range 0..2^DEPTHLOG2.
- Enqueue condition: accept = fetch_valid & fetch_ready & ~flush.
  - Masked lanes are written in ascending lane order to tail, tail+1, and so on. Unmasked lanes are skipped, so no holes are written.
  - Each written entry records its own lane's PC (fetch_pc + 4·lane), not its compacted position.
  - n_in = popcount(fetch_mask) if accept, else 0. A zero mask with accept set is a legal no-op.
- Dequeue condition: ~stall & ~flush.
  - n_out = min(count, 4), else 0.
  - head advances by n_out.
- Window outputs:
  - Combinational reads of storage at head+i, modulo depth, for i = 0..3.
  - inst_word_valid is a thermometer code of min(count, 4), so valid lanes are always contiguous from lane 0.
- fetch_ready is computed only from registered count: (2^DEPTHLOG2 − count) ≥ 4. It does not depend on same-cycle dequeue, which keeps the path from stall to fetch_ready out of the design.
- Update rule: count_next = count + n_in − n_out. Overflow and underflow are impossible by construction.
- Flush takes priority over everything: head, tail and count go to 0 at the next edge, and any fetch in the same cycle is dropped.
- Reset values:
  - head, tail and count are 0.
  - Storage is cleared to 0, so inst_word and inst_pc read 0.
  - inst_word_valid is 0000 and fetch_ready is 1.
- Reset asserted mid-operation clears all state immediately and asynchronously. The outputs take their reset values while reset is held.

## Timing
- Latency from enqueue to window is 1 cycle: a group accepted at edge N is visible on the window outputs after edge N.
- Dequeue takes effect at the edge at which ~stall is sampled. The next window is visible after that edge.
- Enqueue and dequeue may occur in the same cycle. Both pointers update at the same edge.
- Full: with count > depth−4, fetch_ready is 0, and fetch_valid is ignored without loss. The upstream stage holds its group.
- Empty: inst_word_valid is 0000, and stall has no effect.
- Wrap-around: writes and reads that cross entry depth−1 continue at entry 0 within a single cycle.
- Flush during stall: the queue is cleared regardless of stall.

## Configuration
- IFQ_PERF_EN defined: adds two output ports, perf_empty_cycles (32 bits) and perf_full_cycles (32 bits).
  - They count cycles with count == 0 and cycles with fetch_ready == 0, respectively.
  - Both counters saturate at 2^32−1.
  - Both reset to 0 on reset_n. flush does not clear them.
- IFQ_PERF_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Basic flow: after reset, fetch_pc=0x100, mask=1111, stall=0 -> the next cycle shows PCs 0x100/104/108/10C with valid=1111; the cycle after shows valid=0000.
- Compaction: fetch_pc=0x200, mask=1010 -> window lane0 PC=0x204 and lane1 PC=0x20C, valid=0011, words matching lanes 1 and 3.
- Full/backpressure: with DEPTHLOG2=3 and stall=1, enqueue two full groups -> count=8 and fetch_ready=0. A third fetch_valid is ignored. Dropping stall drains 4 entries, after which fetch_ready=1.
- Wrap-around: pre-fill so head=6, then enqueue 4 and dequeue continuously -> PCs remain in program order across the 7→0 boundary, and count is never > 8.
- Flush: with 6 entries queued and flush asserted together with fetch_valid (mask=1111) -> after the edge count=0, valid=0000, fetch_ready=1, and the fetched group is absent.
- Async reset: assert reset_n=0 mid-cycle with 5 entries queued -> valid=0000 immediately. With IFQ_PERF_EN, the counters read 0 after release.
